universal_gate_pipe: RTL and testbench

UNIVERSAL_GATE_PIPE -- requirements
Module: universal_gate_pipe

---
 rtl/universal_gate_pipe.sv | 123 ++++++++++++
 tb/tb_universal_gate_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : universal_gate_pipe
// Brief    : Two-stage valid/ready pipeline applying one of eight bitwise gates
//            to a and b. Define UNIVERSAL_GATE_PIPE_STATS_EN to add op_count.
// Revision : 1.0 - initial release
// ============================================================================
module universal_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       out_mode,
  output logic             busy
`ifdef UNIVERSAL_GATE_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] op_count
`endif
);

  localparam logic [2:0] c_mode_nand = 3'd0;
  localparam logic [2:0] c_mode_nor  = 3'd1;
  localparam logic [2:0] c_mode_and  = 3'd2;
  localparam logic [2:0] c_mode_or   = 3'd3;
  localparam logic [2:0] c_mode_xor  = 3'd4;
  localparam logic [2:0] c_mode_xnor = 3'd5;
  localparam logic [2:0] c_mode_nota = 3'd6;
  localparam logic [2:0] c_mode_bufa = 3'd7;

  generate
    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_param_check
      $error("universal_gate_pipe: WIDTH must be 1..64 and CNT_W at least 1");
    end
  endgenerate

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_mode;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_y;
  logic [2:0]       r_s2_mode;
  logic             w_s2_ready;
  logic [WIDTH-1:0] w_gate_y;

  // S2 can take new data when empty or when its current result leaves now.
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;
  assign out_valid  = r_s2_valid;
  assign y          = r_s2_y;
  assign out_mode   = r_s2_mode;
  assign busy       = r_s1_valid || r_s2_valid;

  always_comb begin
    w_gate_y = '0;
    case (r_s1_mode)
      c_mode_nand: w_gate_y = ~(r_s1_a & r_s1_b);
      c_mode_nor:  w_gate_y = ~(r_s1_a | r_s1_b);
      c_mode_and:  w_gate_y = r_s1_a & r_s1_b;
      c_mode_or:   w_gate_y = r_s1_a | r_s1_b;
      c_mode_xor:  w_gate_y = r_s1_a ^ r_s1_b;
      c_mode_xnor: w_gate_y = ~(r_s1_a ^ r_s1_b);
      c_mode_nota: w_gate_y = ~r_s1_a;
      c_mode_bufa: w_gate_y = r_s1_a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a    <= a;
        r_s1_b    <= b;
        r_s1_mode <= mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_mode  <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_y    <= w_gate_y;
        r_s2_mode <= r_s1_mode;
      end
    end
  end

`ifdef UNIVERSAL_GATE_PIPE_STATS_EN
  logic [CNT_W-1:0] r_op_count;

  // Free-running: wraps to zero silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign op_count = r_op_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_universal_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_gate_pipe
// Brief    : Self-checking bench for universal_gate_pipe at WIDTH 1, 8 and 64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_universal_gate_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [63:0] a_in, b_in;
  logic [2:0]  mode;

  logic        in_ready8, out_valid8, busy8;
  logic [7:0]  y8;
  logic [2:0]  out_mode8;
  logic        in_ready1, out_valid1, busy1;
  logic [0:0]  y1;
  logic [2:0]  out_mode1;
  logic        in_ready64, out_valid64, busy64;
  logic [63:0] y64;
  logic [2:0]  out_mode64;
`ifdef UNIVERSAL_GATE_PIPE_STATS_EN
  logic [3:0]  op_count8, op_count1, op_count64;
`endif

  universal_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a_in[7:0]), .b(b_in[7:0]), .mode(mode), .out_valid(out_valid8),
    .out_ready(out_ready), .y(y8), .out_mode(out_mode8), .busy(busy8)
`ifdef UNIVERSAL_GATE_PIPE_STATS_EN
    , .op_count(op_count8)
`endif
  );

  universal_gate_pipe #(.WIDTH(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a_in[0:0]), .b(b_in[0:0]), .mode(mode), .out_valid(out_valid1),
    .out_ready(out_ready), .y(y1), .out_mode(out_mode1), .busy(busy1)
`ifdef UNIVERSAL_GATE_PIPE_STATS_EN
    , .op_count(op_count1)
`endif
  );

  universal_gate_pipe #(.WIDTH(64), .CNT_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .a(a_in), .b(b_in), .mode(mode), .out_valid(out_valid64),
    .out_ready(out_ready), .y(y64), .out_mode(out_mode64), .busy(busy64)
`ifdef UNIVERSAL_GATE_PIPE_STATS_EN
    , .op_count(op_count64)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  mode;
    int          acc;
  } item_t;
  item_t q[$];

  // Reference: each gate as a 4-entry truth table indexed by {a[i], b[i]}.
  function automatic logic [63:0] golden(input logic [2:0] m, input logic [63:0] x, input logic [63:0] z);
    logic [3:0]  t;
    logic [63:0] r;
    case (m)
      3'd0: t = 4'b0111;
      3'd1: t = 4'b0001;
      3'd2: t = 4'b1000;
      3'd3: t = 4'b1110;
      3'd4: t = 4'b0110;
      3'd5: t = 4'b1001;
      3'd6: t = 4'b0011;
      default: t = 4'b1100;
    endcase
    for (int i = 0; i < 64; i++) r[i] = t[{x[i], z[i]}];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a_in = '1; b_in = '0; mode = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy8); end
    total++; if (y8 !== 8'h00) begin bad++; $display("FAIL reset_y: got %h want 00", y8); end
    total++; if (out_mode8 !== 3'd0) begin bad++; $display("FAIL reset_out_mode: got %0d want 0", out_mode8); end
    total++; if (y64 !== 64'h0) begin bad++; $display("FAIL reset_y64: got %h want 0", y64); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready8); end
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL release_out_valid: got %0b want 0", out_valid8); end
  endtask

  task automatic test_single();
    a_in = 64'hF0; b_in = 64'hCC; mode = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %0b want 1", in_ready8); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %0b want 0", out_valid8); end
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b want 1", busy8); end
    tick();
    total++; if (out_valid8 !== 1'b1) begin bad++; $display("FAIL single_out_valid: got %0b want 1", out_valid8); end
    total++; if (y8 !== 8'h3F) begin bad++; $display("FAIL single_y: got %h want 3f", y8); end
    total++; if (out_mode8 !== 3'd0) begin bad++; $display("FAIL single_out_mode: got %0d want 0", out_mode8); end
    tick();
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL single_drained: got %0b want 0", busy8); end
  endtask

  task automatic test_all_modes();
    logic [7:0] exp_seq [8];
    logic [7:0] got [8];
    int n = 0, first = -1, last = -1;
    exp_seq = '{8'h3F, 8'h03, 8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    a_in = 64'hF0; b_in = 64'hCC; out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 8);
      mode = 3'(c);
      #1;
      if (out_valid8) begin
        if (first < 0) first = c;
        last = c;
        if (n < 8) got[n] = y8;
        n++;
      end
      tick();
    end
    in_valid = 1'b0;
    total++; if (first != 2) begin bad++; $display("FAIL modes_first_cycle: got %0d want 2", first); end
    total++; if (last != 9) begin bad++; $display("FAIL modes_last_cycle: got %0d want 9", last); end
    total++; if (n != 8) begin bad++; $display("FAIL modes_count: got %0d want 8", n); end
    for (int k = 0; k < 8; k++) begin
      total++; if (k < n && got[k] !== exp_seq[k]) begin bad++; $display("FAIL modes_y[%0d]: got %h want %h", k, got[k], exp_seq[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_y [3];
    logic [7:0] got [8];
    int n = 0;
    logic acc, acc2;
    exp_y = '{8'h24, 8'hBD, 8'h99};
    a_in = 64'hA5; b_in = 64'h3C; out_ready = 1'b0; in_valid = 1'b1; acc2 = 1'b0;
    mode = 3'd2; #1;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL bp_ready0: got %0b want 1", in_ready8); end
    tick();
    mode = 3'd3; #1;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL bp_ready1: got %0b want 1", in_ready8); end
    tick();
    mode = 3'd4; #1;
    total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %0b want 0", in_ready8); end
    total++; if (y8 !== 8'h24) begin bad++; $display("FAIL bp_hold_y: got %h want 24", y8); end
    tick();
    total++; if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1 || y8 !== 8'h24) begin
      bad++; $display("FAIL bp_stable: ready=%0b valid=%0b y=%h want 0 1 24", in_ready8, out_valid8, y8);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid8) begin
        if (n < 8) got[n] = y8;
        n++;
      end
      acc = in_valid && in_ready8;
      tick();
      if (acc) begin in_valid = 1'b0; acc2 = 1'b1; end
    end
    total++; if (acc2 !== 1'b1) begin bad++; $display("FAIL bp_third_accepted: got %0b want 1", acc2); end
    total++; if (n != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", n); end
    for (int k = 0; k < 3; k++) begin
      total++; if (k < n && got[k] !== exp_y[k]) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], exp_y[k]); end
    end
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    logic [7:0] gy = 8'h00;
    logic [2:0] gm = 3'd0;
    out_ready = 1'b0; in_valid = 1'b1; a_in = 64'hAA; b_in = 64'h55; mode = 3'd2;
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid8 !== 1'b1 || busy8 !== 1'b1) begin bad++; $display("FAIL rm_prefill: valid=%0b busy=%0b want 1 1", out_valid8, busy8); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL rm_async_valid: got %0b want 0", out_valid8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rm_async_busy: got %0b want 0", busy8); end
    total++; if (y8 !== 8'h00) begin bad++; $display("FAIL rm_async_y: got %h want 00", y8); end
    tick();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; a_in = 64'hF0; b_in = 64'hCC; mode = 3'd4;
    #1;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL rm_first_ready: got %0b want 1", in_ready8); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid8) begin n++; gy = y8; gm = out_mode8; end
      tick();
    end
    total++; if (n != 1) begin bad++; $display("FAIL rm_result_count: got %0d want 1", n); end
    total++; if (gy !== 8'h3C || gm !== 3'd4) begin bad++; $display("FAIL rm_result: got y=%h mode=%0d want 3c 4", gy, gm); end
  endtask

  task automatic test_random();
    int accepted = 0, cyc = 0;
    logic exp_ir, exp_ov;
    logic [63:0] ev;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
    while (accepted < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      a_in      = {$urandom, $urandom};
      b_in      = {$urandom, $urandom};
      mode      = 3'($urandom_range(7));
      out_ready = ($urandom_range(3) != 0);
      #1;
      exp_ir = (q.size() < 2) || out_ready;
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
      total++; if (in_ready8 !== exp_ir || in_ready1 !== exp_ir || in_ready64 !== exp_ir) begin
        bad++; $display("FAIL rnd_in_ready cyc=%0d: got %0b/%0b/%0b want %0b", cyc, in_ready8, in_ready1, in_ready64, exp_ir);
      end
      total++; if (out_valid8 !== exp_ov || out_valid1 !== exp_ov || out_valid64 !== exp_ov) begin
        bad++; $display("FAIL rnd_out_valid cyc=%0d: got %0b/%0b/%0b want %0b", cyc, out_valid8, out_valid1, out_valid64, exp_ov);
      end
      total++; if (busy8 !== (q.size() != 0) || busy1 !== busy8 || busy64 !== busy8) begin
        bad++; $display("FAIL rnd_busy cyc=%0d: got %0b/%0b/%0b want %0b", cyc, busy8, busy1, busy64, q.size() != 0);
      end
      if (out_valid8 && q.size() > 0) begin
        ev = golden(q[0].mode, q[0].a, q[0].b);
        total++; if (y8 !== ev[7:0] || y1 !== ev[0:0] || y64 !== ev) begin
          bad++; $display("FAIL rnd_y cyc=%0d: got %h/%h/%h want %h", cyc, y8, y1, y64, ev);
        end
        total++; if (out_mode8 !== q[0].mode || out_mode1 !== q[0].mode || out_mode64 !== q[0].mode) begin
          bad++; $display("FAIL rnd_out_mode cyc=%0d: got %0d/%0d/%0d want %0d", cyc, out_mode8, out_mode1, out_mode64, q[0].mode);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready8) begin
        q.push_back('{a: a_in, b: b_in, mode: mode, acc: cyc});
        accepted++;
      end
      tick();
      cyc++;
    end
    total++; if (accepted < 10000) begin bad++; $display("FAIL rnd_timeout: got %0d items want 10000", accepted); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (out_valid8 && q.size() > 0) begin
        ev = golden(q[0].mode, q[0].a, q[0].b);
        total++; if (y64 !== ev) begin bad++; $display("FAIL rnd_drain_y: got %h want %h", y64, ev); end
        void'(q.pop_front());
      end
      tick();
    end
    total++; if (q.size() != 0 || busy8 !== 1'b0) begin
      bad++; $display("FAIL rnd_drain: got left=%0d busy=%0b want 0 0", q.size(), busy8);
    end
  endtask

`ifdef UNIVERSAL_GATE_PIPE_STATS_EN
  task automatic test_stats();
    int acc = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (op_count8 !== 4'd0) begin bad++; $display("FAIL stats_reset: got %0d want 0", op_count8); end
    for (int c = 0; c < 40; c++) begin
      in_valid = (acc < 17);
      a_in = {$urandom, $urandom}; mode = 3'($urandom_range(7));
      #1;
      if (in_valid && in_ready8) acc++;
      tick();
    end
    in_valid = 1'b0;
    total++; if (op_count8 !== 4'd1 || op_count64 !== 4'd1) begin
      bad++; $display("FAIL stats_wrap: got %0d/%0d want 1", op_count8, op_count64);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_modes();
    test_backpressure();
    test_reset_midflight();
    test_random();
`ifdef UNIVERSAL_GATE_PIPE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
